oc8051_cxrom_fetch: RTL and testbench

OC8051_CXROM_FETCH -- requirements
Module: oc8051_cxrom_fetch

---
 rtl/oc8051_fetch_pkg.sv | 23 ++
 rtl/oc8051_fetch_queue.sv | 70 +++++++
 rtl/oc8051_cxrom_fetch.sv | 124 ++++++++++++
 tb/tb_oc8051_cxrom_fetch.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/oc8051_fetch_pkg.sv
// ---------------------------------------------------------------------------
// oc8051_fetch_pkg
// Shared types and constants for the oc8051 code-ROM fetch unit.
//   fetch_state_t : FSM state of the fetch front end (FLUSH / STREAM)
//   QDEPTH        : byte-queue depth
//   WIN           : bytes presented to the core per cycle / bytes per ROM read
// ---------------------------------------------------------------------------
package oc8051_fetch_pkg;

  localparam int QDEPTH = 8;
  localparam int WIN    = 4;

  typedef enum logic {
    ST_FLUSH  = 1'b0,
    ST_STREAM = 1'b1
  } fetch_state_t;

  // Clamp a queue occupancy to the visible window size.
  function automatic logic [2:0] win_cnt(input logic [3:0] count);
    return (count > 4'(WIN)) ? 3'(WIN) : count[2:0];
  endfunction

endpackage

// File: rtl/oc8051_fetch_queue.sv
// ---------------------------------------------------------------------------
// oc8051_fetch_queue
// 8-byte circular byte queue: push 4 bytes, pop 0..3 bytes, peek 4 bytes.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_clr         : empty the queue (wins over push/pop)
//   i_push        : append i_push_data (byte 0 in [7:0] first)
//   i_push_data   : 4 bytes to append
//   i_pop_len     : number of bytes to drop from the head (0..3)
//   o_peek        : head 4 bytes, head in [7:0]; empty slots read 8'h00
//   o_count       : current occupancy 0..8
// The caller only pushes when occupancy <= 4, so push slots never collide
// with live or just-popped bytes.
// ---------------------------------------------------------------------------
module oc8051_fetch_queue
  import oc8051_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [31:0] i_push_data,
  input  logic [1:0]  i_pop_len,
  output logic [31:0] o_peek,
  output logic [3:0]  o_count
);

  logic [7:0] r_mem [QDEPTH];
  logic [2:0] r_rd_ptr;
  logic [3:0] r_count;
  logic [2:0] w_wr_ptr;
  logic [2:0] w_wr_idx [WIN];
  logic [2:0] w_rd_idx [WIN];

  assign w_wr_ptr = r_rd_ptr + r_count[2:0];

  genvar gi;
  generate
    for (gi = 0; gi < WIN; gi++) begin : g_win
      assign w_wr_idx[gi] = w_wr_ptr + 3'(gi);
      assign w_rd_idx[gi] = r_rd_ptr + 3'(gi);
      assign o_peek[8*gi +: 8] = (r_count > 4'(gi)) ? r_mem[w_rd_idx[gi]] : 8'h00;
    end
  endgenerate

  // Storage needs no reset: slots beyond the occupancy are masked on peek.
  always_ff @(posedge clk) begin
    if (i_push && !i_clr) begin
      for (int i = 0; i < WIN; i++) begin
        r_mem[w_wr_idx[i]] <= i_push_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + {1'b0, i_pop_len};
      r_count  <= r_count - {2'b00, i_pop_len} + (i_push ? 4'd4 : 4'd0);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/oc8051_cxrom_fetch.sv
// ---------------------------------------------------------------------------
// oc8051_cxrom_fetch
// Instruction-byte fetch front end for an oc8051 core reading a 32-bit wide
// combinational code ROM. Bytes are streamed into an 8-byte queue and the
// core consumes 1..3 bytes per cycle from a 4-byte window.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   cxrom_addr      : ROM byte address (the fill address)
//   cxrom_data_in   : ROM bytes addr..addr+3, byte addr in [7:0]
//   jmp_valid/addr  : redirect; flushes the queue and reloads both addresses
//   consume_valid   : core takes consume_len (1..3) bytes this cycle
//   fetch_pc        : address of fetch_data[7:0]
//   fetch_data      : head 4 bytes; bytes at or above fetch_cnt read 0
//   fetch_cnt       : valid bytes in the window (0..4)
//   stall_cnt       : cycles where the core asked for more than fetch_cnt
// Build option: define OC8051_FETCH_STALL_CNT_EN to implement the saturating
// stall counter; otherwise stall_cnt is tied to 0.
// ---------------------------------------------------------------------------
module oc8051_cxrom_fetch
  import oc8051_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] cxrom_addr,
  input  logic [31:0] cxrom_data_in,
  input  logic        jmp_valid,
  input  logic [15:0] jmp_addr,
  input  logic        consume_valid,
  input  logic [1:0]  consume_len,
  output logic [15:0] fetch_pc,
  output logic [31:0] fetch_data,
  output logic [2:0]  fetch_cnt,
  output logic [15:0] stall_cnt
);

  fetch_state_t r_state, w_state_next;
  logic [15:0]  r_fill_addr;
  logic [15:0]  r_fetch_pc;
  logic [3:0]   w_count;
  logic         w_push;
  logic         w_accept;
  logic [1:0]   w_pop_len;

  assign fetch_cnt = win_cnt(w_count);

  // A consume is all-or-nothing: it is dropped when the window is short.
  assign w_accept  = consume_valid && (consume_len != 2'd0) &&
                     ({1'b0, consume_len} <= fetch_cnt) && !jmp_valid;
  assign w_pop_len = w_accept ? consume_len : 2'd0;

  // Refill whenever 4 free slots exist; FLUSH spends one cycle with no fill
  // so the ROM sees the new address before its data is taken.
  assign w_push = (r_state == ST_STREAM) && (w_count <= 4'd4) && !jmp_valid;

  oc8051_fetch_queue u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (jmp_valid),
    .i_push      (w_push),
    .i_push_data (cxrom_data_in),
    .i_pop_len   (w_pop_len),
    .o_peek      (fetch_data),
    .o_count     (w_count)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FLUSH:  w_state_next = ST_STREAM;
      ST_STREAM: w_state_next = ST_STREAM;
      default:   w_state_next = ST_FLUSH;
    endcase
    if (jmp_valid) begin
      w_state_next = ST_FLUSH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_FLUSH;
      r_fill_addr <= RESET_PC;
      r_fetch_pc  <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      if (jmp_valid) begin
        r_fill_addr <= jmp_addr;
        r_fetch_pc  <= jmp_addr;
      end else begin
        if (w_push) begin
          r_fill_addr <= r_fill_addr + 16'd4;
        end
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + {14'd0, consume_len};
        end
      end
    end
  end

  assign cxrom_addr = r_fill_addr;
  assign fetch_pc   = r_fetch_pc;

`ifdef OC8051_FETCH_STALL_CNT_EN
  logic        w_stall;
  logic [15:0] r_stall_cnt;

  // Counted independently of jmp_valid so redirects never hide a stall.
  assign w_stall = consume_valid && ({1'b0, consume_len} > fetch_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// Directed bench for oc8051_cxrom_fetch. ROM model: byte at address a = a[7:0].
module tb_oc8051_cxrom_fetch;

  logic        clk;
  logic        rst;
  logic [15:0] cxrom_addr;
  logic [31:0] cxrom_data_in;
  logic        jmp_valid;
  logic [15:0] jmp_addr;
  logic        consume_valid;
  logic [1:0]  consume_len;
  logic [15:0] fetch_pc;
  logic [31:0] fetch_data;
  logic [2:0]  fetch_cnt;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

`ifdef OC8051_FETCH_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL1 = 16'd1;
`else
  localparam logic [15:0] EXP_STALL1 = 16'd0;
`endif

  oc8051_cxrom_fetch #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .cxrom_addr    (cxrom_addr),
    .cxrom_data_in (cxrom_data_in),
    .jmp_valid     (jmp_valid),
    .jmp_addr      (jmp_addr),
    .consume_valid (consume_valid),
    .consume_len   (consume_len),
    .fetch_pc      (fetch_pc),
    .fetch_data    (fetch_data),
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt)
  );

  // Combinational ROM
  assign cxrom_data_in = {cxrom_addr[7:0] + 8'd3, cxrom_addr[7:0] + 8'd2,
                          cxrom_addr[7:0] + 8'd1, cxrom_addr[7:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; jmp_valid = 1'b0; jmp_addr = 16'h0000;
    consume_valid = 1'b0; consume_len = 2'd0;
    #3;
    check("rst_cnt",   32'(fetch_cnt),  32'd0);
    check("rst_pc",    32'(fetch_pc),   32'h0000);
    check("rst_data",  fetch_data,      32'h0);
    check("rst_addr",  32'(cxrom_addr), 32'h0000);
    check("rst_stall", 32'(stall_cnt),  32'd0);
    step(); step();
    rst = 1'b0;

    // Power-up streaming
    step();
    check("flush_cnt", 32'(fetch_cnt), 32'd0);
    step();
    check("fill_cnt",  32'(fetch_cnt), 32'd4);
    check("fill_data", fetch_data,     32'h03020100);
    check("fill_pc",   32'(fetch_pc),  32'h0000);
    step();
    check("fill_addr8", 32'(cxrom_addr), 32'h0008);
    step();
    check("addr_hold",  32'(cxrom_addr), 32'h0008);

    // Back-to-back consumes 1,2,3
    consume_valid = 1'b1; consume_len = 2'd1; step();
    check("c1_pc",   32'(fetch_pc), 32'h0001);
    check("c1_data", fetch_data,    32'h04030201);
    consume_len = 2'd2; step();
    check("c2_pc",   32'(fetch_pc), 32'h0003);
    check("c2_data", fetch_data,    32'h06050403);
    consume_len = 2'd3; step();
    check("c3_pc",   32'(fetch_pc),  32'h0006);
    check("c3_cnt",  32'(fetch_cnt), 32'd2);
    check("c3_data", fetch_data,     32'h00000706);
    consume_valid = 1'b0; step();
    check("refill_data", fetch_data,     32'h09080706);
    check("refill_addr", 32'(cxrom_addr), 32'h000C);

    // Jump with a same-cycle consume
    jmp_valid = 1'b1; jmp_addr = 16'h1234;
    consume_valid = 1'b1; consume_len = 2'd2; step();
    jmp_valid = 1'b0; consume_valid = 1'b0;
    check("jmp_pc",   32'(fetch_pc),   32'h1234);
    check("jmp_cnt",  32'(fetch_cnt),  32'd0);
    check("jmp_addr", 32'(cxrom_addr), 32'h1234);
    step();
    check("jmp_flush_cnt", 32'(fetch_cnt), 32'd0);
    step();
    check("jmp_data", fetch_data,    32'h37363534);
    check("jmp_cnt4", 32'(fetch_cnt), 32'd4);

    // Wrap through 16'hFFFF
    jmp_valid = 1'b1; jmp_addr = 16'hFFFE; step();
    jmp_valid = 1'b0;
    step(); step();
    check("wrap_data", fetch_data,     32'h0100FFFE);
    check("wrap_addr", 32'(cxrom_addr), 32'h0002);
    consume_valid = 1'b1; consume_len = 2'd3; step();
    consume_valid = 1'b0;
    check("wrap_pc",    32'(fetch_pc), 32'h0001);
    check("wrap_data2", fetch_data,    32'h04030201);

    // Consume during FLUSH is a stall
    jmp_valid = 1'b1; jmp_addr = 16'h0040; step();
    jmp_valid = 1'b0;
    consume_valid = 1'b1; consume_len = 2'd3; step();
    consume_valid = 1'b0;
    check("stall_cnt", 32'(stall_cnt), 32'(EXP_STALL1));
    check("stall_pc",  32'(fetch_pc),  32'h0040);
    check("stall_cnt0", 32'(fetch_cnt), 32'd0);
    step();
    check("post_stall_data", fetch_data, 32'h43424140);

    // consume_len = 0 is a no-op
    consume_valid = 1'b1; consume_len = 2'd0; step();
    consume_valid = 1'b0;
    check("len0_pc",    32'(fetch_pc),   32'h0040);
    check("len0_addr",  32'(cxrom_addr), 32'h0048);
    check("len0_stall", 32'(stall_cnt),  32'(EXP_STALL1));

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_cnt",   32'(fetch_cnt),  32'd0);
    check("arst_pc",    32'(fetch_pc),   32'h0000);
    check("arst_data",  fetch_data,      32'h0);
    check("arst_addr",  32'(cxrom_addr), 32'h0000);
    check("arst_stall", 32'(stall_cnt),  32'd0);
    step();
    rst = 1'b0;
    step();
    check("rerun_flush", 32'(fetch_cnt), 32'd0);
    step();
    check("rerun_data", fetch_data,     32'h03020100);
    check("rerun_cnt",  32'(fetch_cnt), 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
